mem_access: RTL and testbench

Memory stage directly downstream of `executer`. It accepts one instruction per `run` pulse from the execute stage, passes ALU results straight through to writeback, and performs loads and stores on the data-memory port with a req/ack handshake. Byte-lane steering, load sign/zero extension and misalignment detection are done here. `stall` is asserted back toward the pipeline while a memory transaction is outstanding.

---
 rtl/mem_access_if.sv | 31 +++
 rtl/mem_access.sv | 175 +++++++++++++++++
 tb/tb_mem_access.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_if.sv
// Data-memory port between the memory stage (master) and data memory (slave).
// The request fields are held stable from the request until the acknowledge.
interface mem_access_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;

  modport master (
    output dmem_req,
    output dmem_we,
    output dmem_addr,
    output dmem_be,
    output dmem_wdata,
    input  dmem_ack,
    input  dmem_rdata
  );

  modport slave (
    input  dmem_req,
    input  dmem_we,
    input  dmem_addr,
    input  dmem_be,
    input  dmem_wdata,
    output dmem_ack,
    output dmem_rdata
  );
endinterface

// File: rtl/mem_access.sv
// Memory pipeline stage: ALU passthrough plus loads/stores on a req/ack data port,
// with byte-lane steering, load extension, misalignment and ack-timeout detection.
module mem_access #(
  parameter int unsigned ACK_TIMEOUT = 255
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         run,
  input  logic [31:0]  alu_result,
  input  logic         mem_to_reg,
  input  logic [1:0]   bytes,
  input  logic [31:0]  wdata,
  input  logic         we,
  input  logic         re,
  input  logic [4:0]   rd,
  input  logic         reg_we,
  input  logic         unsigned_flag,
  output logic         stall,
  mem_access_if.master dmem,
  output logic         run_out,
  output logic [31:0]  result_out,
  output logic [4:0]   rd_out,
  output logic         reg_we_out,
  output logic         misaligned,
  output logic         bus_error
);

  localparam int unsigned CntW =
      ($clog2(ACK_TIMEOUT + 1) > 8) ? $clog2(ACK_TIMEOUT + 1) : 8;
  localparam logic [CntW-1:0] CntMax = CntW'(ACK_TIMEOUT - 1);
  localparam bit TimeoutEn = (ACK_TIMEOUT != 0);

  typedef enum logic [0:0] {StIdle, StWaitAck} state_e;

  state_e          state_q;
  logic [CntW-1:0] cnt_q;
  logic [1:0]      bytes_q;
  logic [1:0]      off_q;
  logic            uns_q;
  logic            load_q;
  logic [4:0]      rd_q;
  logic            reg_we_q;
  logic            m2r_q;

  logic [3:0]  be_c;
  logic [31:0] wdata_c;
  logic        mis_c;
  logic [31:0] ld_c;

  // Lane steering and alignment check for the incoming instruction.
  always_comb begin
    be_c    = 4'b1111;
    wdata_c = wdata;
    mis_c   = 1'b0;
    case (bytes)
      2'd0: begin
        be_c    = 4'b0001 << alu_result[1:0];
        wdata_c = {4{wdata[7:0]}};
      end
      2'd1: begin
        be_c    = 4'b0011 << alu_result[1:0];
        wdata_c = {2{wdata[15:0]}};
        mis_c   = alu_result[0];
      end
      2'd2:    mis_c = |alu_result[1:0];
      default: mis_c = 1'b1;
    endcase
  end

  // Load data uses the access fields latched when the request was issued.
  always_comb begin
    ld_c = dmem.dmem_rdata;
    case (bytes_q)
      2'd0: begin
        ld_c[7:0]  = dmem.dmem_rdata[{off_q, 3'b000} +: 8];
        ld_c[31:8] = uns_q ? 24'd0 : {24{ld_c[7]}};
      end
      2'd1: begin
        ld_c[15:0]  = dmem.dmem_rdata[{off_q[1], 4'b0000} +: 16];
        ld_c[31:16] = uns_q ? 16'd0 : {16{ld_c[15]}};
      end
      default: ld_c = dmem.dmem_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q         <= StIdle;
      cnt_q           <= '0;
      bytes_q         <= 2'd0;
      off_q           <= 2'd0;
      uns_q           <= 1'b0;
      load_q          <= 1'b0;
      rd_q            <= 5'd0;
      reg_we_q        <= 1'b0;
      m2r_q           <= 1'b0;
      stall           <= 1'b0;
      dmem.dmem_req   <= 1'b0;
      dmem.dmem_we    <= 1'b0;
      dmem.dmem_addr  <= 32'd0;
      dmem.dmem_be    <= 4'd0;
      dmem.dmem_wdata <= 32'd0;
      run_out         <= 1'b0;
      result_out      <= 32'd0;
      rd_out          <= 5'd0;
      reg_we_out      <= 1'b0;
      misaligned      <= 1'b0;
      bus_error       <= 1'b0;
    end else begin
      run_out    <= 1'b0;
      misaligned <= 1'b0;
      bus_error  <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (run) begin
            if (!we && !re) begin
              result_out <= alu_result;
              rd_out     <= rd;
              reg_we_out <= reg_we;
              run_out    <= 1'b1;
            end else if (mis_c) begin
              rd_out     <= rd;
              reg_we_out <= 1'b0;
              run_out    <= 1'b1;
              misaligned <= 1'b1;
            end else begin
              dmem.dmem_req   <= 1'b1;
              dmem.dmem_we    <= we;
              dmem.dmem_addr  <= {alu_result[31:2], 2'b00};
              dmem.dmem_be    <= be_c;
              dmem.dmem_wdata <= wdata_c;
              stall           <= 1'b1;
              cnt_q           <= '0;
              bytes_q         <= bytes;
              off_q           <= alu_result[1:0];
              uns_q           <= unsigned_flag;
              load_q          <= !we;
              rd_q            <= rd;
              reg_we_q        <= reg_we;
              m2r_q           <= mem_to_reg;
              state_q         <= StWaitAck;
            end
          end
        end
        StWaitAck: begin
          // An ack on the same cycle as the timeout still completes normally.
          if (dmem.dmem_ack) begin
            dmem.dmem_req <= 1'b0;
            stall         <= 1'b0;
            run_out       <= 1'b1;
            rd_out        <= rd_q;
            if (load_q) begin
              result_out <= ld_c;
              reg_we_out <= reg_we_q & m2r_q;
            end else begin
              reg_we_out <= 1'b0;
            end
            state_q <= StIdle;
          end else if (TimeoutEn && (cnt_q == CntMax)) begin
            dmem.dmem_req <= 1'b0;
            stall         <= 1'b0;
            run_out       <= 1'b1;
            bus_error     <= 1'b1;
            rd_out        <= rd_q;
            reg_we_out    <= 1'b0;
            state_q       <= StIdle;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access.sv
// Randomized scoreboard bench for mem_access: expected responses and bus requests are
// queued at issue time and checked by an independent monitor and memory responder.
module tb_mem_access;
  localparam int unsigned Timeout = 4;

  typedef struct {
    logic [31:0] result;
    logic        check_data;
    logic [4:0]  rd;
    logic        reg_we;
    logic        mis;
    logic        berr;
    int          busy;
  } exp_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          delay;
    logic        noack;
  } req_t;

  logic        clk, reset, run, mem_to_reg, we, re, reg_we, unsigned_flag;
  logic [31:0] alu_result, wdata;
  logic [1:0]  bytes;
  logic [4:0]  rd;
  logic        stall, run_out, reg_we_out, misaligned, bus_error;
  logic [31:0] result_out;
  logic [4:0]  rd_out;

  mem_access_if bus ();

  mem_access #(.ACK_TIMEOUT(Timeout)) dut (
    .clk          (clk),
    .reset        (reset),
    .run          (run),
    .alu_result   (alu_result),
    .mem_to_reg   (mem_to_reg),
    .bytes        (bytes),
    .wdata        (wdata),
    .we           (we),
    .re           (re),
    .rd           (rd),
    .reg_we       (reg_we),
    .unsigned_flag(unsigned_flag),
    .stall        (stall),
    .dmem         (bus),
    .run_out      (run_out),
    .result_out   (result_out),
    .rd_out       (rd_out),
    .reg_we_out   (reg_we_out),
    .misaligned   (misaligned),
    .bus_error    (bus_error)
  );

  exp_t sb_q[$];
  req_t req_q[$];
  int   n_vec  = 0;
  int   n_fail = 0;
  int   n_done = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ext_load(input logic [31:0] rdat, input logic [31:0] a,
                                           input int size, input logic uns);
    logic [31:0] v, mask;
    v = rdat >> (8 * (a % 4));
    if (size < 4) begin
      mask = (32'd1 << (8 * size)) - 32'd1;
      v = v & mask;
      if (!uns && v[8*size-1]) v = v | ~mask;
    end
    return v;
  endfunction

  // Monitor: pops the scoreboard whenever the DUT presents a writeback.
  initial begin
    int st_cnt = 0;
    int rq_cnt = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset) begin
        st_cnt = 0;
        rq_cnt = 0;
      end else begin
        if (stall) st_cnt++;
        if (bus.dmem_req) rq_cnt++;
        if (run_out) begin
          if (sb_q.size() == 0) begin
            chk("unexpected_run_out", 32'd1, 32'd0);
          end else begin
            e = sb_q.pop_front();
            if (e.check_data) begin
              chk("result_out", result_out, e.result);
              chk("rd_out", {27'd0, rd_out}, {27'd0, e.rd});
            end
            chk("reg_we_out", {31'd0, reg_we_out}, {31'd0, e.reg_we});
            chk("misaligned", {31'd0, misaligned}, {31'd0, e.mis});
            chk("bus_error", {31'd0, bus_error}, {31'd0, e.berr});
            chk("stall_cycles", st_cnt, e.busy);
            chk("req_cycles", rq_cnt, e.busy);
            chk("stall_at_done", {31'd0, stall}, 32'd0);
          end
          st_cnt = 0;
          rq_cnt = 0;
          n_done++;
        end else begin
          chk("stray_flags", {30'd0, misaligned, bus_error}, 32'd0);
        end
      end
    end
  end

  // Memory responder: checks every request cycle and acks after the queued delay.
  initial begin
    int   cyc = 0;
    logic have = 1'b0;
    req_t cur;
    forever begin
      @(negedge clk);
      bus.dmem_ack   = 1'b0;
      bus.dmem_rdata = $urandom;
      if (!reset) begin
        cyc = 0;
      end else if (bus.dmem_req) begin
        cyc++;
        if (cyc == 1) begin
          have = (req_q.size() != 0);
          if (have) cur = req_q.pop_front();
          else chk("unexpected_dmem_req", 32'd1, 32'd0);
        end
        if (have) begin
          chk("dmem_we", {31'd0, bus.dmem_we}, {31'd0, cur.we});
          chk("dmem_addr", bus.dmem_addr, cur.addr);
          chk("dmem_be", {28'd0, bus.dmem_be}, {28'd0, cur.be});
          chk("dmem_wdata", bus.dmem_wdata, cur.wdata);
          if (!cur.noack && cyc == cur.delay) begin
            bus.dmem_ack   = 1'b1;
            bus.dmem_rdata = cur.rdata;
          end
        end
      end else begin
        cyc = 0;
        bus.dmem_ack = ($urandom_range(0, 3) == 0);  // must be ignored in idle
      end
    end
  end

  task automatic wait_done(input int start);
    logic ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      #1;
      run = 1'b0;
      if (n_done != start) begin
        ok = 1'b1;
      end else if (stall && $urandom_range(0, 2) == 0) begin
        // Protocol violation while busy; the DUT must ignore it.
        run        = 1'b1;
        alu_result = $urandom;
        we         = $urandom_range(0, 1);
        re         = $urandom_range(0, 1);
        wdata      = $urandom;
        rd         = $urandom;
      end
    end
    run = 1'b0;
    if (!ok) chk("completion_timeout", 32'd0, 32'd1);
  endtask

  // Issue one instruction; caller is at negedge+1 with the stage idle.
  task automatic issue(input logic [31:0] a, input logic [1:0] b, input logic w,
                       input logic r, input logic [31:0] wd, input logic [31:0] rdat,
                       input int delay, input logic noack, input logic [4:0] rdi,
                       input logic rwe, input logic m2r, input logic uns);
    exp_t e;
    req_t q;
    int   size, m, start;
    logic mis, is_mem, is_load;
    size    = 1 << b;
    is_mem  = w || r;
    is_load = r && !w;
    mis     = is_mem && ((b == 2'd3) || (a % size != 0));
    e.result     = a;
    e.check_data = !is_mem;
    e.rd         = rdi;
    e.reg_we     = is_mem ? 1'b0 : rwe;
    e.mis        = mis;
    e.berr       = is_mem && !mis && noack;
    e.busy       = (!is_mem || mis) ? 0 : (noack ? int'(Timeout) : delay);
    if (is_mem && !mis) begin
      m       = ((1 << size) - 1) << (a % 4);
      q.we    = w;
      q.addr  = a & ~32'd3;
      q.be    = m[3:0];
      for (int i = 0; i < 4; i++) q.wdata[8*i +: 8] = wd[8*(i % size) +: 8];
      q.rdata = rdat;
      q.delay = delay;
      q.noack = noack;
      req_q.push_back(q);
      if (is_load && !noack) begin
        e.result     = ext_load(rdat, a, size, uns);
        e.check_data = 1'b1;
        e.reg_we     = rwe && m2r;
      end
    end
    sb_q.push_back(e);
    start         = n_done;
    alu_result    = a;
    bytes         = b;
    we            = w;
    re            = r;
    wdata         = wd;
    rd            = rdi;
    reg_we        = rwe;
    mem_to_reg    = m2r;
    unsigned_flag = uns;
    run           = 1'b1;
    wait_done(start);
  endtask

  initial begin
    logic [31:0] a;
    logic [1:0]  b;
    int          kind;
    reset = 1'b0; run = 1'b0; alu_result = 32'd0; bytes = 2'd0; wdata = 32'd0;
    we = 1'b0; re = 1'b0; rd = 5'd0; reg_we = 1'b0; mem_to_reg = 1'b0;
    unsigned_flag = 1'b0; bus.dmem_ack = 1'b0; bus.dmem_rdata = 32'd0;
    #1;
    chk("reset_outputs", {stall, bus.dmem_req, run_out, reg_we_out, misaligned, bus_error},
        32'd0);
    chk("reset_result", result_out, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    #1;

    issue(32'h1234_5678, 2'd2, 1'b0, 1'b0, 32'd0, 32'd0, 1, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0);
    issue(32'h0000_0103, 2'd0, 1'b0, 1'b1, 32'd0, 32'h80FF_0000, 3, 1'b0, 5'd7, 1'b1, 1'b1,
          1'b0);
    issue(32'h0000_0022, 2'd1, 1'b0, 1'b1, 32'd0, 32'hBEEF_1234, 1, 1'b0, 5'd9, 1'b1, 1'b1,
          1'b1);
    issue(32'h0000_0041, 2'd0, 1'b1, 1'b0, 32'h1234_56AB, 32'd0, 2, 1'b0, 5'd3, 1'b1, 1'b0,
          1'b0);
    issue(32'h0000_0002, 2'd2, 1'b0, 1'b1, 32'd0, 32'd0, 1, 1'b0, 5'd4, 1'b1, 1'b1, 1'b0);
    issue(32'h0000_0080, 2'd2, 1'b0, 1'b1, 32'd0, 32'hDEAD_BEEF, 1, 1'b1, 5'd6, 1'b1, 1'b1,
          1'b0);
    issue(32'h0000_0084, 2'd2, 1'b0, 1'b1, 32'd0, 32'hCAFE_F00D, int'(Timeout), 1'b0, 5'd8,
          1'b1, 1'b1, 1'b0);

    // Reset in the middle of an outstanding load: no writeback may follow.
    req_q.push_back('{we: 1'b0, addr: 32'h200, be: 4'hF, wdata: 32'h5555_5555,
                      rdata: 32'd0, delay: 1, noack: 1'b1});
    alu_result = 32'h200; bytes = 2'd2; we = 1'b0; re = 1'b1; wdata = 32'h5555_5555;
    run = 1'b1;
    @(negedge clk);
    #1;
    run = 1'b0;
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    chk("async_reset_req", {31'd0, bus.dmem_req}, 32'd0);
    chk("async_reset_stall", {31'd0, stall}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    #1;
    issue(32'hA5A5_0001, 2'd0, 1'b0, 1'b0, 32'd0, 32'd0, 1, 1'b0, 5'd31, 1'b1, 1'b0, 1'b0);

    for (int k = 0; k < 300; k++) begin
      kind = $urandom_range(0, 9);
      a    = $urandom;
      b    = 2'($urandom_range(0, 3));
      if (b != 2'd3 && $urandom_range(0, 3) != 0) a = a & ~((32'd1 << b) - 32'd1);
      issue(a, b, kind >= 6, (kind >= 3 && kind < 6) || kind == 9, $urandom, $urandom,
            $urandom_range(1, int'(Timeout)), $urandom_range(0, 15) == 0, 5'($urandom),
            1'($urandom), 1'($urandom), 1'($urandom));
    end

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", sb_q.size(), 32'd0);
    chk("requests_drained", req_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
